ssp_tx_fifo: RTL and testbench

//   Transmit FIFO for the SSP. Sits between the APB register interface and the SSP transmit/receive logic.

---
 rtl/ssp_tx_fifo_if.sv | 23 ++
 rtl/ssp_tx_fifo.sv | 55 +++++
 tb/tb_ssp_tx_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ssp_tx_fifo_if.sv
// ssp_tx_fifo_if: APB-side push and SSP-logic-side pop signals of the transmit FIFO
interface ssp_tx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             PSEL;
  logic             PWRITE;
  logic [WIDTH-1:0] PWDATA;
  logic             TxLOGICWRITE;
  logic [WIDTH-1:0] TxDATA;
  logic             TxEMPTY;
  logic             SSPTXINTR;
  logic             TxOVERRUN;
  logic [AW:0]      TxCOUNT;
  modport master (
    output PSEL, PWRITE, PWDATA, TxLOGICWRITE,
    input  TxDATA, TxEMPTY, SSPTXINTR, TxOVERRUN, TxCOUNT
  );
  modport slave (
    input  PSEL, PWRITE, PWDATA, TxLOGICWRITE,
    output TxDATA, TxEMPTY, SSPTXINTR, TxOVERRUN, TxCOUNT
  );
endinterface

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: first-word-fall-through transmit FIFO between APB writes and SSP logic pops
module ssp_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          PCLK,
  input logic          CLEAR,
  ssp_tx_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovr_q, ovr_d, tlw_q;
  logic             empty, full, push_req, pop_req, push_ok, pop_ok;
  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);
  assign push_req      = bus.PSEL & bus.PWRITE;
  assign pop_req       = bus.TxLOGICWRITE & ~tlw_q;
  assign pop_ok        = pop_req & ~empty;
  assign push_ok       = push_req & (~full | pop_ok);
  assign bus.TxEMPTY   = empty;
  assign bus.SSPTXINTR = full;
  assign bus.TxOVERRUN = ovr_q;
  assign bus.TxCOUNT   = count_q;
  assign bus.TxDATA    = empty ? '0 : mem_q[rd_ptr_q];
  // next pointers, occupancy and sticky overrun from this cycle's accepted push/pop
  always_comb begin
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    ovr_d    = ovr_q | (push_req & ~push_ok);
  end
  // control state; clear wins over any push/pop in the same cycle
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      tlw_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      tlw_q    <= bus.TxLOGICWRITE;
    end
  end
  // storage is never cleared; a push coinciding with clear is not written
  always_ff @(posedge PCLK) begin
    if (push_ok && !CLEAR) mem_q[wr_ptr_q] <= bus.PWDATA;
  end
endmodule

// File: tb/tb_ssp_tx_fifo.sv
// tb_ssp_tx_fifo: directed scoreboard bench for the transmit FIFO
module tb_ssp_tx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  logic [7:0] q [$];
  logic       ovr_exp = 1'b0;
  ssp_tx_fifo_if #(.WIDTH(8), .AW(2)) bus ();
  ssp_tx_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (.PCLK(clk), .CLEAR(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(bus.TxCOUNT), 32'(q.size()));
    chk({tag, ".empty"}, 32'(bus.TxEMPTY), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(bus.SSPTXINTR), 32'(q.size() == 4));
    chk({tag, ".ovr"}, 32'(bus.TxOVERRUN), 32'(ovr_exp));
    chk({tag, ".data"}, 32'(bus.TxDATA), q.size() != 0 ? 32'(q[0]) : 32'h0);
  endtask
  task automatic push(input logic [7:0] d);
    bus.PSEL = 1'b1;
    bus.PWRITE = 1'b1;
    bus.PWDATA = d;
    if (q.size() < 4) q.push_back(d);
    else ovr_exp = 1'b1;
    tick();
    bus.PSEL = 1'b0;
    bus.PWRITE = 1'b0;
  endtask
  task automatic pop(input string tag);
    if (q.size() != 0) begin
      chk({tag, ".head"}, 32'(bus.TxDATA), 32'(q[0]));
      void'(q.pop_front());
    end
    bus.TxLOGICWRITE = 1'b1;
    tick();
    bus.TxLOGICWRITE = 1'b0;
    tick();
  endtask
  task automatic clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    ovr_exp = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.PSEL = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PWDATA = 8'h00;
    bus.TxLOGICWRITE = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_state("reset");
    push(8'hA5);
    chk_state("push1");
    pop("pop1");
    chk_state("pop1");
    pop("pop_empty");
    chk_state("pop_empty");
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk_state("fill");
    push(8'h55);
    chk_state("overrun");
    for (int i = 0; i < 4; i++) pop("drain3");
    chk_state("drained3");
    clear();
    chk_state("clear4");
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    bus.PSEL = 1'b1;
    bus.PWRITE = 1'b1;
    bus.PWDATA = 8'h66;
    bus.TxLOGICWRITE = 1'b1;
    chk("simul.head", 32'(bus.TxDATA), 32'(q[0]));
    void'(q.pop_front());
    q.push_back(8'h66);
    tick();
    bus.PSEL = 1'b0;
    bus.PWRITE = 1'b0;
    bus.TxLOGICWRITE = 1'b0;
    chk_state("simul_full");
    tick();
    for (int i = 0; i < 4; i++) pop("drain4");
    chk_state("drained4");
    bus.PSEL = 1'b1;
    bus.PWRITE = 1'b1;
    bus.PWDATA = 8'h77;
    bus.TxLOGICWRITE = 1'b1;
    q.push_back(8'h77);
    tick();
    bus.PSEL = 1'b0;
    bus.PWRITE = 1'b0;
    bus.TxLOGICWRITE = 1'b0;
    chk_state("push_pop_empty");
    tick();
    push(8'h81);
    push(8'h82);
    chk_state("three");
    bus.TxLOGICWRITE = 1'b1;
    void'(q.pop_front());
    for (int i = 0; i < 5; i++) tick();
    bus.TxLOGICWRITE = 1'b0;
    tick();
    chk_state("held_pop");
    for (int i = 0; i < 10; i++) begin
      push(8'hC0 + 8'(i));
      pop("wrap");
    end
    chk_state("wrap_end");
    push(8'hE1);
    chk_state("pre_clear");
    rst = 1'b1;
    bus.PSEL = 1'b1;
    bus.PWRITE = 1'b1;
    bus.PWDATA = 8'hEE;
    tick();
    rst = 1'b0;
    bus.PSEL = 1'b0;
    bus.PWRITE = 1'b0;
    q.delete();
    ovr_exp = 1'b0;
    chk_state("clear_push");
    tick();
    chk_state("clear_after");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
